clock_set_ctrl: RTL
===================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000: clk cycles per second; integer >= 4.
REQ-002 SHALL have parameter TIMEOUT_S, default 10: seconds without a key tic before leaving a set state; integer >= 1.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 SHALL have port arstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tic_mode  input  1  single-cycle pulse from the debounced mode key.
REQ-006 SHALL have port tic_up  input  1  single-cycle pulse from the debounced up key.
REQ-007 SHALL have port tic_down  input  1  single-cycle pulse from the debounced down key.
REQ-008 SHALL have port hours  output  5  current hours, 0-23.
REQ-009 SHALL have port minutes  output  6  current minutes, 0-59.
REQ-010 SHALL have port seconds  output  6  current seconds, 0-59.
REQ-011 SHALL have port state  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN; 3 unused.
REQ-012 SHALL have port blink  output  1  display blank enable for the field being edited.
REQ-013 SHALL have port sec_pulse  output  1  one-cycle strobe coinciding with each seconds update in RUN.

Function
REQ-014 SHALL contain a prescaler counting 0..CLK_FREQ-1. In RUN it SHALL increment every cycle; at CLK_FREQ-1 it SHALL wrap to 0, and seconds SHALL advance on the same edge.
REQ-015 Time SHALL roll over as follows: seconds 59->0 with minutes+1; minutes 59->0 with hours+1; 23:59:59 -> 00:00:00 on a single edge.
REQ-016 FSM transitions on tic_mode: RUN->SET_HOUR, SET_HOUR->SET_MIN, SET_MIN->RUN. All three outputs SHALL update on the edge sampling the tic.
REQ-017 In SET_HOUR, tic_up SHALL make hours+1 (23->0), and tic_down SHALL make hours-1 (0->23).
REQ-018 In SET_MIN, tic_up SHALL make minutes+1 (59->0), and tic_down SHALL make minutes-1 (0->59); hours SHALL be unaffected (no carry/borrow).
REQ-019 In RUN, tic_up and tic_down SHALL be ignored.
REQ-020 If tic_up and tic_down are asserted in the same cycle, there SHALL be no change.
REQ-021 If tic_mode is asserted with tic_up or tic_down, the state change SHALL apply and the value tics SHALL be ignored.
REQ-022 Entering SET_HOUR SHALL clear the prescaler and seconds to 0 and freeze timekeeping; sec_pulse SHALL stay 0 in set states.
REQ-023 Returning to RUN (by tic or timeout) SHALL restart the prescaler from 0. The first sec_pulse SHALL occur CLK_FREQ cycles after the transition edge.
REQ-024 blink SHALL be 0 in RUN. In set states, a blink counter SHALL toggle blink every CLK_FREQ/4 cycles. Every state-entry edge and every accepted up/down tic SHALL clear the blink counter and force blink to 0 (edited field visible).
REQ-025 Adjustments SHALL be visible on outputs one cycle after the tic (registered outputs, no combinational path from tic inputs to outputs).

Reset
REQ-026 While arstn=0: hours=0, minutes=0, seconds=0, state=RUN, blink=0, sec_pulse=0, and all internal counters=0, independent of clk.
REQ-027 Reset mid-set-state SHALL return to RUN with time 00:00:00. Timekeeping SHALL resume on the first clk edge after deassertion.

Configuration
REQ-028 Macro CLOCK_SET_TIMEOUT_EN defined: an inactivity counter SHALL be cleared on entry to a set state and on every tic. On reaching TIMEOUT_S*CLK_FREQ cycles, it SHALL force state=RUN with REQ-023 behaviour.
REQ-029 Macro CLOCK_SET_TIMEOUT_EN undefined: no inactivity counter SHALL be synthesized; set states SHALL exit only via tic_mode; TIMEOUT_S SHALL be unused.

Verification (CLK_FREQ=8, TIMEOUT_S=2)
REQ-030 Reset, run 8*86400 cycles -> sec_pulse count=86400, final time 00:00:00, single-edge wrap from 23:59:59.
REQ-031 tic_mode, then 3x tic_down -> state=1, hours=21; tic_mode, then tic_up at minutes=59 -> minutes=0, hours=21 unchanged.
REQ-032 In SET_MIN, tic_up+tic_down same cycle -> no change; tic_mode+tic_up same cycle -> state=0, minutes unchanged, seconds=0.
REQ-033 With CLOCK_SET_TIMEOUT_EN: enter SET_HOUR, idle 16 cycles -> state=0 on cycle 16; with the macro undefined -> state stays 1.
REQ-034 In SET_HOUR, observe blink -> toggles every 2 cycles; a tic_up forces blink=0 on the next cycle; in RUN blink=0.
REQ-035 Assert arstn=0 asynchronously mid-SET_MIN at 12:34 -> outputs 00:00:00, state=0 immediately; first sec_pulse 8 cycles after release.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Settable 24h clock: RUN / SET_HOUR / SET_MIN with prescaler and edit blink.
// Optional inactivity timeout in set states: `define CLOCK_SET_TIMEOUT_EN.
module clock_set_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       tic_mode,
  input  logic       tic_up,
  input  logic       tic_down,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] state,
  output logic       blink,
  output logic       sec_pulse
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam int PRE_W = $clog2(CLK_FREQ);
  localparam int BLK_N = CLK_FREQ / 4;
  localparam int BLK_W = (BLK_N > 1) ? $clog2(BLK_N) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLK_N - 1);

  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [BLK_W-1:0] r_blk;
  logic [4:0]       r_hr;
  logic [5:0]       r_min;
  logic [5:0]       r_sec;
  logic             r_blink;
  logic             r_pulse;

  logic       w_any;
  logic       w_adj;
  logic       w_wrap;
  logic       w_to;
  logic [4:0] w_hr_inc;
  logic [4:0] w_hr_dec;
  logic [5:0] w_min_inc;
  logic [5:0] w_min_dec;

  assign w_any  = tic_mode | tic_up | tic_down;
  assign w_adj  = tic_up ^ tic_down;
  assign w_wrap = (r_pre == PRE_MAX);

  assign w_hr_inc  = (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
  assign w_hr_dec  = (r_hr == 5'd0) ? 5'd23 : r_hr - 5'd1;
  assign w_min_inc = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
  assign w_min_dec = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;

`ifdef CLOCK_SET_TIMEOUT_EN
  localparam longint TO_N = longint'(TIMEOUT_S) * longint'(CLK_FREQ);
  localparam int     TO_W = $clog2(TO_N);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_N - 1);

  logic [TO_W-1:0] r_idle;

  // Any key activity, or being in RUN, restarts the idle window.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_idle <= '0;
    end else if (r_state == RUN || w_any || w_to) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + TO_W'(1);
    end
  end

  assign w_to = (r_state != RUN) && !w_any && (r_idle == TO_MAX);
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= RUN;
      r_pre   <= '0;
      r_blk   <= '0;
      r_hr    <= '0;
      r_min   <= '0;
      r_sec   <= '0;
      r_blink <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      unique case (r_state)
        RUN: begin
          if (tic_mode) begin
            r_state <= SET_HOUR;
            r_pre   <= '0;
            r_sec   <= '0;
            r_blk   <= '0;
            r_blink <= 1'b0;
          end else if (w_wrap) begin
            r_pre   <= '0;
            r_pulse <= 1'b1;
            if (r_sec == 6'd59) begin
              r_sec <= '0;
              if (r_min == 6'd59) begin
                r_min <= '0;
                r_hr  <= w_hr_inc;
              end else begin
                r_min <= r_min + 6'd1;
              end
            end else begin
              r_sec <= r_sec + 6'd1;
            end
          end else begin
            r_pre <= r_pre + PRE_W'(1);
          end
        end
        SET_HOUR, SET_MIN: begin
          if (tic_mode) begin
            r_state <= (r_state == SET_HOUR) ? SET_MIN : RUN;
            r_pre   <= '0;
            r_blk   <= '0;
            r_blink <= 1'b0;
          end else if (w_to) begin
            r_state <= RUN;
            r_pre   <= '0;
            r_blk   <= '0;
            r_blink <= 1'b0;
          end else if (w_adj) begin
            // Edited field stays visible right after every accepted step.
            r_blk   <= '0;
            r_blink <= 1'b0;
            if (r_state == SET_HOUR) begin
              r_hr <= tic_up ? w_hr_inc : w_hr_dec;
            end else begin
              r_min <= tic_up ? w_min_inc : w_min_dec;
            end
          end else if (r_blk == BLK_MAX) begin
            r_blk   <= '0;
            r_blink <= ~r_blink;
          end else begin
            r_blk <= r_blk + BLK_W'(1);
          end
        end
        default: begin
          r_state <= RUN;
          r_pre   <= '0;
          r_blk   <= '0;
          r_blink <= 1'b0;
        end
      endcase
    end
  end

  assign hours     = r_hr;
  assign minutes   = r_min;
  assign seconds   = r_sec;
  assign state     = r_state;
  assign blink     = r_blink;
  assign sec_pulse = r_pulse;

endmodule
